alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
Sequencer in front of the 8-bit combinational ALU. Accepts one operation per valid/ready handshake and drives the ALU operand and opcode lines. Chains up to three ALU passes for 16-bit ADD16/SUB16. Composes the S/Z/H/PV flags the ALU leaves at zero, maintains the architectural F register, and returns result plus flags over a valid/ready response channel.

Parameters:
ALU_WIDTH, 8, ALU datapath width; only 8 is supported; any other value must fail elaboration.
IDLE_OPCODE, 5'b11111, ALU opcode driven while not computing; selects the ALU default case, which outputs 0.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request valid
req_ready  output  1  high only in IDLE
req_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CP, 6 INC, 7 DEC, 8 ADD16, 9 SUB16; 10-15 illegal
req_a  input  16  operand A; narrow ops use [7:0]
req_b  input  16  operand B; narrow ops use [7:0]; ignored by INC/DEC
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_result  output  16  result; narrow ops zero-extended
rsp_err  output  1  illegal op
f_reg  output  8  F: bit7 S, 6 Z, 4 H, 2 PV, 1 N, 0 C; bits 5 and 3 always 0
f_wr_en  input  1  external F load (POP AF)
f_wr_data  input  8  F load value; bits 5 and 3 forced 0
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_opcode  output  5  to ALU opcode: ADD 0, SUB 1, AND 2, OR 3, XOR 4, INC 12, DEC 13
alu_out  input  8  from ALU out
alu_flags  input  8  from ALU status; only bits 0 (C), 1 (N) and 2 (PV) are used

Behaviour:
- Reset (async): state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, f_reg=0x00, alu_opcode=IDLE_OPCODE, alu_a=alu_b=0.
- Reset mid-operation aborts the operation: no response is produced, and F is not updated.
- ALU lines are driven from registered state only; alu_out is sampled at the end of the same cycle.
- States: IDLE, LO, HI, FIX, RESP.
- IDLE, on req_valid & req_ready: capture op and operands, go to LO.
- LO: low-byte pass.
  - CP issues SUB; INC/DEC issue INC/DEC on a[7:0].
  - Narrow ops go to RESP.
  - Wide ops latch the low result and low carry, then go to HI.
- HI: ADD or SUB of the high bytes; latch high carry.
  - Low carry=1 goes to FIX; otherwise go to RESP.
- FIX: INC (ADD16) or DEC (SUB16) of the HI result.
  - Final C = high carry | (ADD16: HI result 0xFF) | (SUB16: HI result 0x00).
  - Go to RESP.
- RESP: rsp_valid=1; rsp_result, rsp_err and f_reg hold stable until rsp_ready. Handshake returns to IDLE (no same-cycle re-accept).
- Latency from the accept cycle to rsp_valid: narrow 2 cycles; wide without fix 3; wide with fix 4.
- F is written on the edge entering RESP:
  - ADD/SUB/CP:
    - S=res[7], Z=(res==0).
    - H=(a^b^res)[4].
    - PV, N and C taken from the ALU.
    - CP rsp_result = a[7:0] (the ALU result is discarded).
  - AND/OR/XOR:
    - S and Z as above; H=1 for AND, 0 otherwise.
    - PV = even parity of res; N=0, C=0.
  - INC:
    - S and Z as above; H=(a[3:0]==0xF); PV=(a==0x7F); N=0; C preserved.
  - DEC:
    - S and Z as above; H=(a[3:0]==0x0); PV=(a==0x80); N=1; C preserved.
  - ADD16/SUB16:
    - S=res[15], Z=(res==0); H=0, PV=0.
    - N = 0 for ADD16, 1 for SUB16; C is the final carry.
  - Illegal ops:
    - Pass through LO with alu_opcode=IDLE_OPCODE.
    - Result 0, rsp_err=1, F unchanged.
- f_wr_en loads F on any edge; if it coincides with the edge entering RESP, the completion write wins and the load is dropped.

Optional Feature:
ALU_CTRL_PERF_EN.
- Defined: adds output ports perf_ops[15:0] and perf_fix[15:0], both reset to 0.
  - perf_ops increments on each rsp handshake.
  - perf_fix increments on each FIX entry.
  - Both counters wrap at 0xFFFF to 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the req_op enum;
  - ALU opcode constants matching the ALU encoding;
  - the state enum;
  - F bit-index constants;
  - IDLE_OPCODE default.
- One sub-module, alu_ctrl_flags: purely combinational F composer taking (op, a, b, res, alu_flags, old F) and producing the new F.

Test Plan:
- ADD a=0x7F b=0x01 -> rsp_result=0x0080, f_reg=0x94, rsp_valid 2 cycles after accept.
- CP a=0x05 b=0x05 -> rsp_result=0x0005, f_reg=0x42.
- f_wr 0x01, then INC a=0xFF -> rsp_result=0x0000, f_reg=0x51 (C preserved).
- ADD16 0x00FF+0x0001 -> 0x0100, f_reg=0x00, latency 4, one FIX pass. ADD16 0xFFFF+0x0001 -> 0x0000, f_reg=0x41. ADD16 0x0102+0x0101 -> 0x0203, latency 3.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result and f_reg stable; req_ready=0. Assert rst during HI -> rsp_valid=0, req_ready=1, f_reg=0x00 asynchronously.
- Illegal op 0xC -> rsp_err=1, result 0, F unchanged. f_wr_en on the RESP-entry edge -> F equals the completion value.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencer: request opcodes, ALU
// opcode encoding, FSM states and F register bit positions.
package alu_ctrl_pkg;

  localparam int unsigned OPC_W = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_CP    = 4'd5,
    OP_INC   = 4'd6,
    OP_DEC   = 4'd7,
    OP_ADD16 = 4'd8,
    OP_SUB16 = 4'd9
  } req_op_e;

  // Opcode encoding understood by the downstream combinational ALU
  localparam logic [OPC_W-1:0] ALU_OP_ADD = 5'd0;
  localparam logic [OPC_W-1:0] ALU_OP_SUB = 5'd1;
  localparam logic [OPC_W-1:0] ALU_OP_AND = 5'd2;
  localparam logic [OPC_W-1:0] ALU_OP_OR  = 5'd3;
  localparam logic [OPC_W-1:0] ALU_OP_XOR = 5'd4;
  localparam logic [OPC_W-1:0] ALU_OP_INC = 5'd12;
  localparam logic [OPC_W-1:0] ALU_OP_DEC = 5'd13;

  // Hits the ALU default case, which outputs zero
  localparam logic [OPC_W-1:0] IDLE_OPCODE_DEF = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam int unsigned F_S  = 7;
  localparam int unsigned F_Z  = 6;
  localparam int unsigned F_H  = 4;
  localparam int unsigned F_PV = 2;
  localparam int unsigned F_N  = 1;
  localparam int unsigned F_C  = 0;

  // Bits 5 and 3 of F never hold state
  localparam logic [7:0] F_MASK = 8'hD7;

  function automatic logic is_wide(input req_op_e op);
    return (op == OP_ADD16) || (op == OP_SUB16);
  endfunction

  function automatic logic is_legal(input req_op_e op);
    return op <= OP_SUB16;
  endfunction

endpackage

// File: rtl/alu_ctrl_flags.sv
// Combinational F composer: builds the new F value for a completing
// operation from its operands, result and the ALU's C/N/PV outputs.
module alu_ctrl_flags
  import alu_ctrl_pkg::*;
(
  input  req_op_e     op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] res,
  input  logic [2:0]  alu_flags,
  input  logic [7:0]  f_old,
  output logic [7:0]  f_new
);

  logic [7:0] r8;
  logic       h_arith;

  assign r8      = res[7:0];
  assign h_arith = a[4] ^ b[4] ^ r8[4];

  // Per-op flag composition; illegal ops leave F untouched
  always_comb begin
    f_new = f_old;
    case (op)
      OP_ADD, OP_SUB, OP_CP: begin
        f_new       = 8'h00;
        f_new[F_S]  = r8[7];
        f_new[F_Z]  = (r8 == 8'h00);
        f_new[F_H]  = h_arith;
        f_new[F_PV] = alu_flags[2];
        f_new[F_N]  = alu_flags[1];
        f_new[F_C]  = alu_flags[0];
      end
      OP_AND, OP_OR, OP_XOR: begin
        f_new       = 8'h00;
        f_new[F_S]  = r8[7];
        f_new[F_Z]  = (r8 == 8'h00);
        f_new[F_H]  = (op == OP_AND);
        f_new[F_PV] = ~^r8;
      end
      OP_INC: begin
        f_new       = 8'h00;
        f_new[F_S]  = r8[7];
        f_new[F_Z]  = (r8 == 8'h00);
        f_new[F_H]  = (a[3:0] == 4'hF);
        f_new[F_PV] = (a == 8'h7F);
        f_new[F_C]  = f_old[F_C];
      end
      OP_DEC: begin
        f_new       = 8'h00;
        f_new[F_S]  = r8[7];
        f_new[F_Z]  = (r8 == 8'h00);
        f_new[F_H]  = (a[3:0] == 4'h0);
        f_new[F_PV] = (a == 8'h80);
        f_new[F_N]  = 1'b1;
        f_new[F_C]  = f_old[F_C];
      end
      OP_ADD16, OP_SUB16: begin
        f_new       = 8'h00;
        f_new[F_S]  = res[15];
        f_new[F_Z]  = (res == 16'h0000);
        f_new[F_N]  = (op == OP_SUB16);
        f_new[F_C]  = alu_flags[0];
      end
      default: f_new = f_old;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer in front of the 8-bit combinational ALU. Runs one pass for
// 8-bit ops and up to three passes (LO, HI, FIX) for ADD16/SUB16, keeps
// the F register and returns result plus flags on a valid/ready channel.
// Optional: define ALU_CTRL_PERF_EN to add perf_ops/perf_fix counters.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned      ALU_WIDTH   = 8,
  parameter logic [OPC_W-1:0] IDLE_OPCODE = IDLE_OPCODE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [15:0]          req_a,
  input  logic [15:0]          req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic [7:0]           f_reg,
  input  logic                 f_wr_en,
  input  logic [7:0]           f_wr_data,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic [OPC_W-1:0]     alu_opcode,
  input  logic [ALU_WIDTH-1:0] alu_out,
  input  logic [7:0]           alu_flags
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_ops,
  output logic [15:0]          perf_fix
`endif
);

  if (ALU_WIDTH != 8) begin : g_width_check
    $error("alu_ctrl: only ALU_WIDTH = 8 is supported");
  end

  state_e                 state, state_d;
  req_op_e                op_q, op_d;
  logic [15:0]            a_q, a_d, b_q, b_d;
  logic [7:0]             lo_res_q, lo_res_d;
  logic                   lo_c_q, lo_c_d, hi_c_q, hi_c_d;
  logic [ALU_WIDTH-1:0]   alu_a_d, alu_b_d;
  logic [OPC_W-1:0]       alu_opcode_d;
  logic                   req_ready_d, rsp_valid_d, rsp_err_d;
  logic [15:0]            rsp_result_d;
  logic [7:0]             f_d, f_new;
  logic                   done;
  logic [15:0]            fl_res;
  logic [2:0]             fl_flags;
  logic                   fix_c;
  logic                   unused_flags;

  assign unused_flags = ^alu_flags[7:3];

  // Opcode for the first (low byte) pass; illegal ops idle the ALU
  function automatic logic [OPC_W-1:0] lo_opcode(input req_op_e op);
    case (op)
      OP_ADD, OP_ADD16:        return ALU_OP_ADD;
      OP_SUB, OP_CP, OP_SUB16: return ALU_OP_SUB;
      OP_AND:                  return ALU_OP_AND;
      OP_OR:                   return ALU_OP_OR;
      OP_XOR:                  return ALU_OP_XOR;
      OP_INC:                  return ALU_OP_INC;
      OP_DEC:                  return ALU_OP_DEC;
      default:                 return IDLE_OPCODE;
    endcase
  endfunction

  // Result and C/N/PV seen by the flag composer in the completing state
  always_comb begin
    fl_res   = {8'h00, alu_out};
    fl_flags = alu_flags[2:0];
    // FIX carry: HI carry, or the INC/DEC of the HI byte wrapped
    fix_c    = hi_c_q | ((op_q == OP_ADD16) ? (alu_a == 8'hFF) : (alu_a == 8'h00));
    case (state)
      ST_HI:   fl_res = {alu_out, lo_res_q};
      ST_FIX: begin
        fl_res   = {alu_out, lo_res_q};
        fl_flags = {2'b00, fix_c};
      end
      default: ;
    endcase
  end

  alu_ctrl_flags u_flags (
    .op        (op_q),
    .a         (a_q[7:0]),
    .b         (b_q[7:0]),
    .res       (fl_res),
    .alu_flags (fl_flags),
    .f_old     (f_reg),
    .f_new     (f_new)
  );

  // Next-state and next-value logic for every register
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    lo_res_d     = lo_res_q;
    lo_c_d       = lo_c_q;
    hi_c_d       = hi_c_q;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_opcode_d = IDLE_OPCODE;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    rsp_err_d    = rsp_err;
    f_d          = f_wr_en ? (f_wr_data & F_MASK) : f_reg;
    done         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d         = req_op_e'(req_op);
          a_d          = req_a;
          b_d          = req_b;
          alu_a_d      = is_legal(op_d) ? req_a[7:0] : 8'h00;
          alu_b_d      = (is_legal(op_d) && op_d != OP_INC && op_d != OP_DEC) ? req_b[7:0] : 8'h00;
          alu_opcode_d = lo_opcode(op_d);
          state_d      = ST_LO;
        end
      end
      ST_LO: begin
        if (is_wide(op_q)) begin
          lo_res_d     = alu_out;
          lo_c_d       = alu_flags[0];
          alu_a_d      = a_q[15:8];
          alu_b_d      = b_q[15:8];
          alu_opcode_d = (op_q == OP_ADD16) ? ALU_OP_ADD : ALU_OP_SUB;
          state_d      = ST_HI;
        end else begin
          done = 1'b1;
        end
      end
      ST_HI: begin
        hi_c_d = alu_flags[0];
        if (lo_c_q) begin
          alu_a_d      = alu_out;
          alu_opcode_d = (op_q == OP_ADD16) ? ALU_OP_INC : ALU_OP_DEC;
          state_d      = ST_FIX;
        end else begin
          done = 1'b1;
        end
      end
      ST_FIX: done = 1'b1;
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion: publish the response; the F update beats any external load
    if (done) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = !is_legal(op_q);
      if (!is_legal(op_q))
        rsp_result_d = 16'h0000;
      else if (op_q == OP_CP)
        rsp_result_d = {8'h00, a_q[7:0]};
      else
        rsp_result_d = fl_res;
      f_d = f_new;
    end

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      lo_res_q   <= 8'h00;
      lo_c_q     <= 1'b0;
      hi_c_q     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= IDLE_OPCODE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_err    <= 1'b0;
      f_reg      <= 8'h00;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lo_res_q   <= lo_res_d;
      lo_c_q     <= lo_c_d;
      hi_c_q     <= hi_c_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_opcode <= alu_opcode_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      rsp_err    <= rsp_err_d;
      f_reg      <= f_d;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  // Completed-response and FIX-pass counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops <= 16'h0000;
      perf_fix <= 16'h0000;
    end else begin
      if (state == ST_RESP && rsp_ready)
        perf_ops <= perf_ops + 16'd1;
      if (state != ST_FIX && state_d == ST_FIX)
        perf_fix <= perf_fix + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural model of the 8-bit ALU.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, f_wr_en;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b, rsp_result;
  logic [7:0]  f_reg, f_wr_data, alu_a, alu_b, alu_out, alu_flags;
  logic [4:0]  alu_opcode;
  logic [8:0]  m_sum;
`ifdef ALU_CTRL_PERF_EN
  logic [15:0] perf_ops, perf_fix;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat, fixes;

  alu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .f_reg      (f_reg),
    .f_wr_en    (f_wr_en),
    .f_wr_data  (f_wr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags)
`ifdef ALU_CTRL_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_fix   (perf_fix)
`endif
  );

  always #5 clk = ~clk;

  // ALU model: bit0 C (carry/borrow), bit1 N, bit2 PV (signed overflow)
  always_comb begin
    m_sum     = 9'h000;
    alu_out   = 8'h00;
    alu_flags = 8'h00;
    case (alu_opcode)
      5'd0: begin
        m_sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = m_sum[7:0];
        alu_flags[0] = m_sum[8];
        alu_flags[2] = (alu_a[7] == alu_b[7]) && (m_sum[7] != alu_a[7]);
      end
      5'd1: begin
        m_sum        = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out      = m_sum[7:0];
        alu_flags[0] = m_sum[8];
        alu_flags[1] = 1'b1;
        alu_flags[2] = (alu_a[7] != alu_b[7]) && (m_sum[7] != alu_a[7]);
      end
      5'd2:  alu_out = alu_a & alu_b;
      5'd3:  alu_out = alu_a | alu_b;
      5'd4:  alu_out = alu_a ^ alu_b;
      5'd12: alu_out = alu_a + 8'd1;
      5'd13: alu_out = alu_a - 8'd1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic f_write(input logic [7:0] d);
    @(negedge clk);
    f_wr_en   = 1'b1;
    f_wr_data = d;
    @(posedge clk); #1;
    f_wr_en   = 1'b0;
  endtask

  // Present a request; returns #1 after the accepting edge (DUT in LO)
  task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycles counted from the accept cycle until rsp_valid, bounded
  task automatic wait_rsp(output int l, output int fx);
    l  = 1;
    fx = 0;
    while (!rsp_valid && l < 20) begin
      if (alu_opcode == 5'd12 || alu_opcode == 5'd13) fx++;
      @(posedge clk); #1;
      l++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [7:0] exp_f, input int exp_lat);
    start_op(op, a, b);
    wait_rsp(lat, fixes);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, rsp_result, exp_res);
    check({tag, "_f"}, f_reg, exp_f);
    check({tag, "_err"}, rsp_err, 0);
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;
    rsp_ready = 1'b0; f_wr_en = 1'b0; f_wr_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_err", rsp_err, 0);
    check("rst_f", f_reg, 8'h00);
    check("rst_opcode", alu_opcode, 5'h1F);
    check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
    rst = 1'b0;

    run_op("add", 4'd0, 16'h007F, 16'h0001, 16'h0080, 8'h94, 2);
    run_op("cp", 4'd5, 16'h0005, 16'h0005, 16'h0005, 8'h42, 2);
    f_write(8'h01);
    check("fwr_01", f_reg, 8'h01);
    run_op("inc", 4'd6, 16'h00FF, 16'h1234, 16'h0000, 8'h51, 2);
    run_op("and", 4'd2, 16'h00F0, 16'h003C, 16'h0030, 8'h14, 2);
    run_op("xor", 4'd4, 16'h00FF, 16'h00FF, 16'h0000, 8'h44, 2);
    run_op("dec", 4'd7, 16'h0080, 16'h0000, 16'h007F, 8'h16, 2);
    run_op("sub", 4'd1, 16'h0010, 16'h0020, 16'h00F0, 8'h83, 2);

    run_op("add16_fix", 4'd8, 16'h00FF, 16'h0001, 16'h0100, 8'h00, 4);
    check("add16_fix_passes", fixes, 1);
    run_op("add16_wrap", 4'd8, 16'hFFFF, 16'h0001, 16'h0000, 8'h41, 4);
    run_op("add16_nofix", 4'd8, 16'h0102, 16'h0101, 16'h0203, 8'h00, 3);
    check("add16_nofix_passes", fixes, 0);
    run_op("sub16_fix", 4'd9, 16'h0100, 16'h0001, 16'h00FF, 8'h02, 4);
    run_op("sub16_wrap", 4'd9, 16'h0000, 16'h0001, 16'hFFFF, 8'h83, 4);

    // Back-pressure: response must hold while rsp_ready is low
    start_op(4'd0, 16'h007F, 16'h0001);
    wait_rsp(lat, fixes);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_res", rsp_result, 16'h0080);
      check("hold_f", f_reg, 8'h94);
      check("hold_req_ready", req_ready, 0);
    end
    finish_rsp();
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_req_ready", req_ready, 1);

    f_write(8'hFF);
    check("fwr_mask", f_reg, 8'hD7);

    // Illegal opcode: error response, F untouched, ALU idled
    f_write(8'h55);
    start_op(4'hC, 16'h1234, 16'h5678);
    check("ill_opcode", alu_opcode, 5'h1F);
    wait_rsp(lat, fixes);
    check("ill_lat", lat, 2);
    check("ill_err", rsp_err, 1);
    check("ill_res", rsp_result, 16'h0000);
    check("ill_f", f_reg, 8'h55);
    finish_rsp();

    // External F load on the RESP-entry edge loses to the completion
    start_op(4'd0, 16'h0001, 16'h0001);
    @(negedge clk);
    f_wr_en   = 1'b1;
    f_wr_data = 8'hFF;
    @(posedge clk); #1;
    f_wr_en   = 1'b0;
    check("race_valid", rsp_valid, 1);
    check("race_res", rsp_result, 16'h0002);
    check("race_f", f_reg, 8'h00);
    @(posedge clk); #1;
    check("race_f_hold", f_reg, 8'h00);
    finish_rsp();

    // Asynchronous reset while in HI aborts the operation
    f_write(8'h55);
    start_op(4'd8, 16'h0102, 16'h0101);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_f", f_reg, 8'h00);
    check("arst_opcode", alu_opcode, 5'h1F);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_rsp", rsp_valid, 0);
    check("arst_f_kept", f_reg, 8'h00);
    run_op("add_after_rst", 4'd0, 16'h007F, 16'h0001, 16'h0080, 8'h94, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
